// File: rtl/dwc_parallel_window.sv
// rtl/dwc_parallel_window.sv - unpacks one wide sliding-window beat into NF*SF narrow SIMD x PE beats
//
// Purpose:
//   Holds one complete window (KERNEL_PROD kernel positions x CHANNELS channels)
//   and replays it as NF*SF output beats in fold order: nf outer, sf inner.
//   Output lane (s, p) carries activation (k = nf*PE + p, c = sf*SIMD + s).
//
// Ports:
//   ap_clk                in   clock, rising edge
//   ap_rst_n              in   asynchronous active-low reset
//   s_axis_input_tdata    in   IN_WIDTH window, activation (k, c) at [(k*CHANNELS+c)*AW +: AW]
//   s_axis_input_tvalid   in   input valid
//   s_axis_input_tready   out  input ready
//   m_axis_output_tdata   out  OUT_WIDTH beat, lane (s, p) at [(s*PE+p)*AW +: AW]
//   m_axis_output_tvalid  out  output valid
//   m_axis_output_tready  in   output ready
//
// Configuration:
//   DWC_PARALLEL_WINDOW_ASSERT_EN  compiles in simulation-only protocol assertions.

module dwc_parallel_window #(
  parameter int SIMD             = 3,
  parameter int PE               = 2,
  parameter int CHANNELS         = 9,
  parameter int KERNEL_PROD      = 4,
  parameter int ACTIVATION_WIDTH = 4,
  parameter int IN_WIDTH         = 144,
  parameter int OUT_WIDTH        = 24
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  s_axis_input_tdata,
  input  logic                 s_axis_input_tvalid,
  output logic                 s_axis_input_tready,
  output logic [OUT_WIDTH-1:0] m_axis_output_tdata,
  output logic                 m_axis_output_tvalid,
  input  logic                 m_axis_output_tready
);

  localparam int AW   = ACTIVATION_WIDTH;
  localparam int SF   = CHANNELS / SIMD;
  localparam int NF   = KERNEL_PROD / PE;
  localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
  localparam int SF_W = (SF > 1) ? $clog2(SF) : 1;
  localparam int K_W  = (KERNEL_PROD > 1) ? $clog2(KERNEL_PROD) : 1;
  localparam int C_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [KERNEL_PROD-1:0][CHANNELS-1:0][AW-1:0] window_t;
  typedef logic [SIMD-1:0][PE-1:0][AW-1:0]              beat_t;
  typedef logic [NF_W-1:0]                               nf_t;
  typedef logic [SF_W-1:0]                               sf_t;

  localparam nf_t NF_LAST = nf_t'(NF - 1);
  localparam sf_t SF_LAST = sf_t'(SF - 1);

  // Parameter consistency is checked at elaboration.
  if (IN_WIDTH != KERNEL_PROD * CHANNELS * ACTIVATION_WIDTH) begin : g_in_width_err
    $error("IN_WIDTH must equal KERNEL_PROD*CHANNELS*ACTIVATION_WIDTH");
  end
  if (OUT_WIDTH != SIMD * PE * ACTIVATION_WIDTH) begin : g_out_width_err
    $error("OUT_WIDTH must equal SIMD*PE*ACTIVATION_WIDTH");
  end
  if ((CHANNELS % SIMD) != 0) begin : g_simd_err
    $error("SIMD must divide CHANNELS");
  end
  if ((KERNEL_PROD % PE) != 0) begin : g_pe_err
    $error("PE must divide KERNEL_PROD");
  end

  window_t window_q;
  logic    full_q, full_d;
  nf_t     nf_q, nf_d;
  sf_t     sf_q, sf_d;
  beat_t   beat;

  logic last_beat;
  logic in_hs;
  logic out_hs;

  assign last_beat = (nf_q == NF_LAST) && (sf_q == SF_LAST);

  // Ready may look at the output side only on the last beat, so a new
  // window can replace the old one in the same edge the last beat leaves.
  assign s_axis_input_tready  = ap_rst_n & (~full_q | (last_beat & m_axis_output_tready));
  assign m_axis_output_tvalid = full_q;

  assign in_hs  = s_axis_input_tvalid & s_axis_input_tready;
  assign out_hs = full_q & m_axis_output_tready;

  always_comb begin
    full_d = full_q;
    nf_d   = nf_q;
    sf_d   = sf_q;
    if (in_hs) begin
      full_d = 1'b1;
      nf_d   = '0;
      sf_d   = '0;
    end else if (out_hs) begin
      if (sf_q == SF_LAST) begin
        sf_d = '0;
        if (nf_q == NF_LAST) begin
          nf_d   = '0;
          full_d = 1'b0;
        end else begin
          nf_d = nf_q + nf_t'(1);
        end
      end else begin
        sf_d = sf_q + sf_t'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      full_q <= 1'b0;
      nf_q   <= '0;
      sf_q   <= '0;
    end else begin
      full_q <= full_d;
      nf_q   <= nf_d;
      sf_q   <= sf_d;
    end
  end

  // Window payload is pure data; it needs no reset because full_q gates it.
  always_ff @(posedge ap_clk) begin
    if (in_hs) begin
      window_q <= window_t'(s_axis_input_tdata);
    end
  end

  // Output lanes are a register-only mux selected by the fold counters.
  always_comb begin
    logic [K_W-1:0] k_idx;
    logic [C_W-1:0] c_idx;
    beat  = '0;
    k_idx = '0;
    c_idx = '0;
    for (int s = 0; s < SIMD; s++) begin
      for (int p = 0; p < PE; p++) begin
        k_idx      = K_W'(int'(nf_q) * PE + p);
        c_idx      = C_W'(int'(sf_q) * SIMD + s);
        beat[s][p] = window_q[k_idx][c_idx];
      end
    end
  end

  assign m_axis_output_tdata = beat;

`ifdef DWC_PARALLEL_WINDOW_ASSERT_EN
  a_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (m_axis_output_tvalid && !m_axis_output_tready)
      |=> (m_axis_output_tvalid && $stable(m_axis_output_tdata)));

  a_no_overwrite: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (in_hs && full_q) |-> (last_beat && m_axis_output_tready));

  a_nf_range: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (int'(nf_q) < NF));

  a_sf_range: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (int'(sf_q) < SF));
`else
`endif

endmodule

// File: tb/tb_dwc_parallel_window.sv
// tb/tb_dwc_parallel_window.sv - directed self-checking bench for dwc_parallel_window
module tb_dwc_parallel_window;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [143:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [23:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dwc_parallel_window dut (
    .ap_clk               (clk),
    .ap_rst_n             (rst_n),
    .s_axis_input_tdata   (s_tdata),
    .s_axis_input_tvalid  (s_tvalid),
    .s_axis_input_tready  (s_tready),
    .m_axis_output_tdata  (m_tdata),
    .m_axis_output_tvalid (m_tvalid),
    .m_axis_output_tready (m_tready)
  );

  // Window whose activation (k, c) is (9k + c + off) mod 16.
  function automatic logic [143:0] mk_window(input int off);
    logic [143:0] w;
    w = '0;
    for (int i = 0; i < 36; i++) w[i*4 +: 4] = 4'((i + off) % 16);
    return w;
  endfunction

  // Expected beat (nf, sf): lane (s, p) = activation (k = 2nf + p, c = 3sf + s).
  function automatic logic [23:0] exp_beat(input int off, input int nf, input int sf);
    logic [23:0] b;
    b = '0;
    for (int s = 0; s < 3; s++)
      for (int p = 0; p < 2; p++)
        b[(s*2 + p)*4 +: 4] = 4'((9*(nf*2 + p) + sf*3 + s + off) % 16);
    return b;
  endfunction

  function automatic logic [143:0] garbage();
    return 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  // Offers a window and waits (bounded) for acceptance; returns at the
  // falling edge of the cycle right after the accepting edge.
  task automatic send_window(input int off);
    int t;
    @(negedge clk);
    s_tdata  = mk_window(off);
    s_tvalid = 1'b1;
    #1;
    t = 0;
    while (s_tready !== 1'b1 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept off=%0d: tready=%b required 1", off, s_tready);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tdata  = garbage();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b required 0", s_tready); end
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL release_tready: got %b required 1", s_tready); end
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL release_tvalid: got %b required 0", m_tvalid); end
  endtask

  task automatic test_one_window;
    m_tready = 1'b1;
    send_window(0);
    for (int b = 0; b < 6; b++) begin
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL one_valid beat %0d: got %b required 1", b, m_tvalid); end
      n_cmp++;
      if (m_tdata !== exp_beat(0, b / 3, b % 3)) begin
        n_fail++; $display("FAIL one_data beat %0d: got %h required %h", b, m_tdata, exp_beat(0, b / 3, b % 3));
      end
      if (b == 0) begin
        n_cmp++;
        if (m_tdata !== 24'hB2A190) begin n_fail++; $display("FAIL one_beat00_const: got %h required b2a190", m_tdata); end
      end
      if (b == 5) begin
        n_cmp++;
        if (m_tdata[3:0] !== 4'd8) begin n_fail++; $display("FAIL one_beat12_lane00: got %0d required 8", m_tdata[3:0]); end
        n_cmp++;
        if (m_tdata[7:4] !== 4'd1) begin n_fail++; $display("FAIL one_beat12_lane01: got %0d required 1", m_tdata[7:4]); end
        n_cmp++;
        if (m_tdata !== 24'h3A2918) begin n_fail++; $display("FAIL one_beat12_const: got %h required 3a2918", m_tdata); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL one_after_valid: got %b required 0", m_tvalid); end
  endtask

  task automatic test_random_stall;
    int beats;
    int cyc;
    logic stalled;
    logic [23:0] prev;
    m_tready = 1'b0;
    send_window(0);
    beats   = 0;
    cyc     = 0;
    stalled = 1'b0;
    prev    = '0;
    while (beats < 6 && cyc < 200) begin
      m_tready = ($urandom_range(0, 6) < 4);
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b1) begin
        n_fail++; $display("FAIL rs_valid cycle %0d: got %b required 1", cyc, m_tvalid);
      end else begin
        n_cmp++;
        if (m_tdata !== exp_beat(0, beats / 3, beats % 3)) begin
          n_fail++; $display("FAIL rs_data beat %0d: got %h required %h", beats, m_tdata, exp_beat(0, beats / 3, beats % 3));
        end
        if (stalled) begin
          n_cmp++;
          if (m_tdata !== prev) begin n_fail++; $display("FAIL rs_hold cycle %0d: got %h required %h", cyc, m_tdata, prev); end
        end
      end
      stalled = m_tvalid & ~m_tready;
      prev    = m_tdata;
      if (m_tvalid && m_tready) beats++;
      cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (beats != 6) begin n_fail++; $display("FAIL rs_beat_count: got %0d required 6", beats); end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rs_after_valid: got %b required 0", m_tvalid); end
  endtask

  task automatic test_back_to_back;
    int off;
    m_tready = 1'b1;
    @(negedge clk);
    s_tdata  = mk_window(3);
    s_tvalid = 1'b1;
    #1;
    n_cmp++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_accept: got %b required 1", s_tready); end
    @(negedge clk);
    s_tdata = mk_window(7);
    for (int c = 0; c < 12; c++) begin
      if (c == 6) begin
        s_tvalid = 1'b0;
        s_tdata  = garbage();
      end
      #1;
      off = (c < 6) ? 3 : 7;
      n_cmp++;
      if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid cycle %0d: got %b required 1", c, m_tvalid); end
      n_cmp++;
      if (m_tdata !== exp_beat(off, (c % 6) / 3, c % 3)) begin
        n_fail++; $display("FAIL b2b_data cycle %0d: got %h required %h", c, m_tdata, exp_beat(off, (c % 6) / 3, c % 3));
      end
      if (c < 6) begin
        n_cmp++;
        if (s_tready !== (c == 5)) begin n_fail++; $display("FAIL b2b_tready cycle %0d: got %b required %b", c, s_tready, (c == 5)); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_after_valid: got %b required 0", m_tvalid); end
  endtask

  task automatic test_reset_mid;
    m_tready = 1'b1;
    send_window(5);
    for (int b = 0; b < 3; b++) begin
      #1;
      n_cmp++;
      if (m_tdata !== exp_beat(5, 0, b)) begin n_fail++; $display("FAIL rm_pre_data beat %0d: got %h required %h", b, m_tdata, exp_beat(5, 0, b)); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_tvalid_drop: got %b required 0", m_tvalid); end
    n_cmp++;
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rm_tready_drop: got %b required 0", s_tready); end
    @(negedge clk);
    rst_n = 1'b1;
    send_window(9);
    for (int b = 0; b < 6; b++) begin
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(9, b / 3, b % 3)) begin
        n_fail++; $display("FAIL rm_post beat %0d: valid=%b data=%h required valid=1 data=%h", b, m_tvalid, m_tdata, exp_beat(9, b / 3, b % 3));
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_after_valid: got %b required 0", m_tvalid); end
  endtask

  task automatic test_stall_hold;
    m_tready = 1'b0;
    send_window(2);
    s_tdata  = mk_window(11);
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (s_tready !== 1'b0) begin n_fail++; $display("FAIL sh_stall_tready cycle %0d: got %b required 0", i, s_tready); end
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(2, 0, 0)) begin
        n_fail++; $display("FAIL sh_stall_out cycle %0d: valid=%b data=%h required valid=1 data=%h", i, m_tvalid, m_tdata, exp_beat(2, 0, 0));
      end
      @(negedge clk);
    end
    m_tready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      #1;
      n_cmp++;
      if (m_tdata !== exp_beat(2, b / 3, b % 3)) begin n_fail++; $display("FAIL sh_first beat %0d: got %h required %h", b, m_tdata, exp_beat(2, b / 3, b % 3)); end
      n_cmp++;
      if (s_tready !== (b == 5)) begin n_fail++; $display("FAIL sh_tready beat %0d: got %b required %b", b, s_tready, (b == 5)); end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tdata  = garbage();
    for (int b = 0; b < 6; b++) begin
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_beat(11, b / 3, b % 3)) begin
        n_fail++; $display("FAIL sh_second beat %0d: valid=%b data=%h required valid=1 data=%h", b, m_tvalid, m_tdata, exp_beat(11, b / 3, b % 3));
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL sh_after_valid: got %b required 0", m_tvalid); end
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    test_reset();
    test_one_window();
    test_random_stall();
    test_back_to_back();
    test_reset_mid();
    test_stall_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
